bus_protocol_monitor: RTL and testbench

- Synthesizable, multi-channel runtime monitor for the dValid/dAck/data transfer protocol. It replaces fixed-length, single-channel simulation-only assertions with parametrised checking in RTL.
- Sits passively beside N_CH master/target pairs. Per channel it reports: protocol violations as coded errors, sticky error flags, and a count of completed transfers.
- Usable in simulation, emulation and silicon debug.

---
 rtl/bus_protocol_monitor.sv | 184 ++++++++++++++++++
 tb/tb_bus_protocol_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_protocol_monitor.sv
// Passive multi-channel checker for the dValid/dAck/data transfer protocol.
// Latency: one cycle. An event sampled at edge n is reported in the cycle after edge n.
// Backpressure: none. The monitor only observes the bus and never stalls it.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   clear             zeroes err_flags and xfer_cnt; channel FSMs keep running
//   dValid/dAck/data  per-channel observed bus, channel i data at [i*DATA_W +: DATA_W]
//   err_valid/code/ch pulse and code/channel of the lowest-numbered erroring channel
//   err_flags         sticky per-channel error bits, 8 per channel, indexed by code
//   xfer_done/cnt     per-channel clean-completion pulse and wrapping count
module bus_protocol_monitor #(
    parameter  int DATA_W    = 8,
    parameter  int N_CH      = 4,
    parameter  int MIN_VALID = 2,
    parameter  int MAX_VALID = 4,
    parameter  int CNT_W     = 16,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [N_CH-1:0]          dValid,
    input  logic [N_CH-1:0]          dAck,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [CH_W-1:0]          err_ch,
    output logic [N_CH*8-1:0]        err_flags,
    output logic [N_CH-1:0]          xfer_done,
    output logic [N_CH*CNT_W-1:0]    xfer_cnt
);

    localparam int K_W = $clog2(MAX_VALID + 1);
    localparam logic [K_W-1:0] K_ONE = K_W'(1);
    localparam logic [K_W-1:0] K_MIN = K_W'(MIN_VALID);
    localparam logic [K_W-1:0] K_MAX = K_W'(MAX_VALID);

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_EARLY = 3'd1;
    localparam logic [2:0] E_LONG  = 3'd2;
    localparam logic [2:0] E_NOACK = 3'd3;
    localparam logic [2:0] E_DATA  = 3'd4;
    localparam logic [2:0] E_HOLD  = 3'd5;
    localparam logic [2:0] E_SPUR  = 3'd6;

    typedef enum logic [1:0] {IDLE, ACTIVE, ACKED, DRAIN} state_t;

    // k holds the index (1-based) of the next dValid-high sample in ACTIVE.
    state_t              state    [N_CH];
    logic [K_W-1:0]      k        [N_CH];
    logic [DATA_W-1:0]   data_q   [N_CH];

    state_t              state_nxt[N_CH];
    logic [K_W-1:0]      k_nxt    [N_CH];
    logic [2:0]          code_nxt [N_CH];
    logic [N_CH-1:0]     done_nxt;
    logic [N_CH-1:0]     latch;
    logic [N_CH*8-1:0]   new_flags;
    logic [2:0]          sel_code;
    logic [CH_W-1:0]     sel_ch;
    logic                any_err;

    always_comb begin
        logic [K_W-1:0]    kk;
        logic              eval;
        logic [DATA_W-1:0] d;
        done_nxt  = '0;
        latch     = '0;
        new_flags = '0;
        for (int i = 0; i < N_CH; i++) begin
            kk           = K_ONE;
            eval         = 1'b0;
            d            = data[i*DATA_W +: DATA_W];
            code_nxt[i]  = E_NONE;
            state_nxt[i] = state[i];
            k_nxt[i]     = '0;

            case (state[i])
                IDLE: begin
                    if (dValid[i]) begin
                        // First high sample is judged by the ACTIVE rules at k=1.
                        latch[i] = 1'b1;
                        eval     = 1'b1;
                        kk       = K_ONE;
                    end else if (dAck[i]) begin
                        code_nxt[i] = E_SPUR;
                    end
                end
                ACTIVE: begin
                    if (dValid[i]) begin
                        eval = 1'b1;
                        kk   = k[i];
                    end else begin
                        code_nxt[i]  = E_NOACK;
                        state_nxt[i] = IDLE;
                    end
                end
                ACKED: begin
                    if (dValid[i]) begin
                        code_nxt[i]  = E_HOLD;
                        state_nxt[i] = DRAIN;
                    end else if (dAck[i]) begin
                        code_nxt[i]  = E_SPUR;
                        state_nxt[i] = IDLE;
                    end else begin
                        done_nxt[i]  = 1'b1;
                        state_nxt[i] = IDLE;
                    end
                end
                DRAIN: begin
                    if (!dValid[i]) state_nxt[i] = IDLE;
                end
                default: state_nxt[i] = IDLE;
            endcase

            if (eval) begin
                // Data stability only applies once a value has been latched.
                if (kk > K_ONE && d != data_q[i]) begin
                    code_nxt[i]  = E_DATA;
                    state_nxt[i] = DRAIN;
                end else if (dAck[i]) begin
                    if (kk < K_MIN) code_nxt[i] = E_EARLY;
                    state_nxt[i] = ACKED;
                end else if (kk == K_MAX) begin
                    code_nxt[i]  = E_LONG;
                    state_nxt[i] = DRAIN;
                end else begin
                    k_nxt[i]     = kk + K_ONE;
                    state_nxt[i] = ACTIVE;
                end
            end

            if (code_nxt[i] != E_NONE) new_flags[i*8 + int'(code_nxt[i])] = 1'b1;
        end
    end

    // Lowest channel index wins the shared report; scan high to low so it lands last.
    always_comb begin
        sel_code = E_NONE;
        sel_ch   = '0;
        any_err  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (code_nxt[i] != E_NONE) begin
                sel_code = code_nxt[i];
                sel_ch   = CH_W'(i);
                any_err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i]  <= IDLE;
                k[i]      <= '0;
                data_q[i] <= '0;
            end
            err_valid <= 1'b0;
            err_code  <= E_NONE;
            err_ch    <= '0;
            err_flags <= '0;
            xfer_done <= '0;
            xfer_cnt  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nxt[i];
                k[i]     <= k_nxt[i];
                if (latch[i]) data_q[i] <= data[i*DATA_W +: DATA_W];
                // A clear coinciding with a completion leaves exactly that completion counted.
                if (clear)
                    xfer_cnt[i*CNT_W +: CNT_W] <= CNT_W'(done_nxt[i]);
                else
                    xfer_cnt[i*CNT_W +: CNT_W] <= xfer_cnt[i*CNT_W +: CNT_W] + CNT_W'(done_nxt[i]);
            end
            err_valid <= any_err;
            err_code  <= sel_code;
            err_ch    <= sel_ch;
            err_flags <= clear ? new_flags : (err_flags | new_flags);
            xfer_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Directed bench for bus_protocol_monitor with N_CH=4, DATA_W=8, MIN=2, MAX=4, CNT_W=4.
// Each step drives one sample, waits for the edge, and checks registered outputs #1 later.
// Expected values are hand-derived from the protocol rules.
module tb_bus_protocol_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  dValid;
    logic [3:0]  dAck;
    logic [31:0] data;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [1:0]  err_ch;
    logic [31:0] err_flags;
    logic [3:0]  xfer_done;
    logic [15:0] xfer_cnt;

    int errors = 0;
    int checks = 0;
    logic seen;

    always #5 clk = ~clk;

    bus_protocol_monitor #(
        .DATA_W(8), .N_CH(4), .MIN_VALID(2), .MAX_VALID(4), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .dValid(dValid), .dAck(dAck), .data(data),
        .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
        .err_flags(err_flags), .xfer_done(xfer_done), .xfer_cnt(xfer_cnt)
    );

    task automatic step(input logic [3:0] v, input logic [3:0] a, input logic [31:0] d, input logic clr);
        dValid = v; dAck = a; data = d; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(4'hF, 4'hF, 32'h0, 1'b0);
        step(4'h0, 4'hF, 32'h0, 1'b0);
        reset = 1'b0;
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %0b want 0", err_valid); end
        checks++; if (err_flags !== 32'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", err_flags); end
        checks++; if (xfer_cnt !== 16'h0 || xfer_done !== 4'h0) begin errors++; $display("FAIL reset_cnt: got cnt=%h done=%h want 0", xfer_cnt, xfer_done); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic test_clean();
        seen = 1'b0;
        step(4'h1, 4'h0, 32'hA5, 1'b0); seen |= err_valid;
        step(4'h1, 4'h0, 32'hA5, 1'b0); seen |= err_valid;
        step(4'h1, 4'h1, 32'hA5, 1'b0); seen |= err_valid;
        checks++; if (xfer_done !== 4'h0) begin errors++; $display("FAIL clean_done_early: got %h want 0", xfer_done); end
        step(4'h0, 4'h0, 32'h0, 1'b0); seen |= err_valid;
        checks++; if (xfer_done !== 4'h1) begin errors++; $display("FAIL clean_done: got %h want 1", xfer_done); end
        checks++; if (xfer_cnt[3:0] !== 4'd1) begin errors++; $display("FAIL clean_cnt: got %0d want 1", xfer_cnt[3:0]); end
        step(4'h0, 4'h0, 32'h0, 1'b0); seen |= err_valid;
        checks++; if (xfer_done !== 4'h0) begin errors++; $display("FAIL clean_done_pulse: got %h want 0", xfer_done); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clean_noerr: got %0b want 0", seen); end
    endtask

    task automatic test_lengths();
        seen = 1'b0;
        // length 2, ack in last cycle
        step(4'h1, 4'h0, 32'h11, 1'b0); seen |= err_valid;
        step(4'h1, 4'h1, 32'h11, 1'b0); seen |= err_valid;
        step(4'h0, 4'h0, 32'h0, 1'b0);  seen |= err_valid;
        // length 4, ack in last cycle
        step(4'h1, 4'h0, 32'h22, 1'b0); seen |= err_valid;
        step(4'h1, 4'h0, 32'h22, 1'b0); seen |= err_valid;
        step(4'h1, 4'h0, 32'h22, 1'b0); seen |= err_valid;
        step(4'h1, 4'h1, 32'h22, 1'b0); seen |= err_valid;
        step(4'h0, 4'h0, 32'h0, 1'b0);  seen |= err_valid;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL len2_4_noerr: got %0b want 0", seen); end
        checks++; if (xfer_cnt[3:0] !== 4'd3) begin errors++; $display("FAIL len2_4_cnt: got %0d want 3", xfer_cnt[3:0]); end
        // length 5, never acked
        step(4'h1, 4'h0, 32'h33, 1'b0);
        step(4'h1, 4'h0, 32'h33, 1'b0);
        step(4'h1, 4'h0, 32'h33, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL long_not_yet: got %0b want 0", err_valid); end
        step(4'h1, 4'h0, 32'h33, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd2 || err_ch !== 2'd0) begin errors++; $display("FAIL long_code: got v=%0b code=%0d ch=%0d want 1/2/0", err_valid, err_code, err_ch); end
        step(4'h1, 4'h0, 32'h33, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL long_drain: got %0b want 0", err_valid); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
        // ack in the first cycle
        step(4'h1, 4'h1, 32'h44, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin errors++; $display("FAIL early_code: got v=%0b code=%0d want 1/1", err_valid, err_code); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
        checks++; if (xfer_done !== 4'h1 || xfer_cnt[3:0] !== 4'd4) begin errors++; $display("FAIL early_counted: got done=%h cnt=%0d want 1/4", xfer_done, xfer_cnt[3:0]); end
        checks++; if (err_flags[7:0] !== 8'h06) begin errors++; $display("FAIL flags_early_long: got %h want 06", err_flags[7:0]); end
    endtask

    task automatic test_hold_spur_noack();
        step(4'h1, 4'h0, 32'h55, 1'b0);
        step(4'h1, 4'h1, 32'h55, 1'b0);
        step(4'h1, 4'h0, 32'h55, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd5) begin errors++; $display("FAIL hold_code: got v=%0b code=%0d want 1/5", err_valid, err_code); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
        checks++; if (xfer_done !== 4'h0 || xfer_cnt[3:0] !== 4'd4) begin errors++; $display("FAIL hold_uncounted: got done=%h cnt=%0d want 0/4", xfer_done, xfer_cnt[3:0]); end
        // ack two cycles wide
        step(4'h1, 4'h0, 32'h66, 1'b0);
        step(4'h1, 4'h1, 32'h66, 1'b0);
        step(4'h0, 4'h1, 32'h0, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd6) begin errors++; $display("FAIL spur_acked: got v=%0b code=%0d want 1/6", err_valid, err_code); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
        // ack with no transfer at all
        step(4'h0, 4'h1, 32'h0, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd6) begin errors++; $display("FAIL spur_idle: got v=%0b code=%0d want 1/6", err_valid, err_code); end
        // dValid falls after 3 cycles, no ack
        step(4'h1, 4'h0, 32'h77, 1'b0);
        step(4'h1, 4'h0, 32'h77, 1'b0);
        step(4'h1, 4'h0, 32'h77, 1'b0);
        step(4'h0, 4'h0, 32'h0, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL noack_code: got v=%0b code=%0d want 1/3", err_valid, err_code); end
    endtask

    task automatic test_data();
        step(4'h1, 4'h0, 32'h3C, 1'b0);
        step(4'h1, 4'h0, 32'h3D, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd4) begin errors++; $display("FAIL data_code: got v=%0b code=%0d want 1/4", err_valid, err_code); end
        seen = 1'b0;
        step(4'h1, 4'h0, 32'h3D, 1'b0); seen |= err_valid;
        step(4'h1, 4'h1, 32'h3D, 1'b0); seen |= err_valid;
        step(4'h0, 4'h0, 32'h0, 1'b0);  seen |= err_valid;
        checks++; if (seen !== 1'b0 || xfer_cnt[3:0] !== 4'd4) begin errors++; $display("FAIL data_drain_silent: got err=%0b cnt=%0d want 0/4", seen, xfer_cnt[3:0]); end
        checks++; if (err_flags[7:0] !== 8'h7E) begin errors++; $display("FAIL flags_ch0_all: got %h want 7E", err_flags[7:0]); end
    endtask

    task automatic test_simultaneous();
        step(4'h0, 4'h0, 32'h0, 1'b1);
        checks++; if (err_flags !== 32'h0 || xfer_cnt !== 16'h0) begin errors++; $display("FAIL clear_zero: got flags=%h cnt=%h want 0/0", err_flags, xfer_cnt); end
        // ch2 runs four samples unacked; ch1 starts one later and holds after its ack
        step(4'b0100, 4'b0000, 32'h0012_3400, 1'b0);
        step(4'b0110, 4'b0000, 32'h0012_3400, 1'b0);
        step(4'b0110, 4'b0010, 32'h0012_3400, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL simul_quiet: got %0b want 0", err_valid); end
        step(4'b0110, 4'b0000, 32'h0012_3400, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_ch !== 2'd1 || err_code !== 3'd5) begin errors++; $display("FAIL simul_report: got v=%0b ch=%0d code=%0d want 1/1/5", err_valid, err_ch, err_code); end
        checks++; if (err_flags !== 32'h0004_2000) begin errors++; $display("FAIL simul_flags: got %h want 00042000", err_flags); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL simul_idle: got %0b want 0", err_valid); end
    endtask

    task automatic test_clear_overlap();
        step(4'b0000, 4'b1000, 32'h0, 1'b1);
        checks++; if (err_flags !== 32'h4000_0000 || err_ch !== 2'd3 || err_code !== 3'd6) begin errors++; $display("FAIL clear_with_err: got flags=%h ch=%0d code=%0d want 40000000/3/6", err_flags, err_ch, err_code); end
        step(4'h1, 4'h0, 32'h9, 1'b0);
        step(4'h1, 4'h1, 32'h9, 1'b0);
        step(4'h0, 4'h0, 32'h0, 1'b0);
        step(4'h1, 4'h0, 32'h8, 1'b0);
        step(4'h1, 4'h1, 32'h8, 1'b0);
        step(4'h0, 4'h0, 32'h0, 1'b1);
        checks++; if (xfer_cnt[3:0] !== 4'd1 || xfer_done !== 4'h1 || err_flags !== 32'h0) begin errors++; $display("FAIL clear_with_done: got cnt=%0d done=%h flags=%h want 1/1/0", xfer_cnt[3:0], xfer_done, err_flags); end
    endtask

    task automatic test_reset_mid();
        step(4'h1, 4'h0, 32'hAB, 1'b0);
        step(4'h1, 4'h0, 32'hAB, 1'b0);
        reset = 1'b1;
        step(4'h1, 4'h0, 32'hAB, 1'b0);
        reset = 1'b0;
        checks++; if (err_valid !== 1'b0 || xfer_cnt !== 16'h0) begin errors++; $display("FAIL reset_mid_outputs: got v=%0b cnt=%h want 0/0", err_valid, xfer_cnt); end
        step(4'h0, 4'h0, 32'h0, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_no_noack: got %0b want 0", err_valid); end
    endtask

    task automatic test_back_to_back_wrap();
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            step(4'h1, 4'h0, 32'h5A, 1'b0); seen |= err_valid;
            step(4'h1, 4'h1, 32'h5A, 1'b0); seen |= err_valid;
            step(4'h0, 4'h0, 32'h0, 1'b0);  seen |= err_valid;
        end
        checks++; if (xfer_cnt[3:0] !== 4'd15 || seen !== 1'b0) begin errors++; $display("FAIL b2b_cnt15: got cnt=%0d err=%0b want 15/0", xfer_cnt[3:0], seen); end
        step(4'h1, 4'h0, 32'h5A, 1'b0);
        step(4'h1, 4'h1, 32'h5A, 1'b0);
        step(4'h0, 4'h0, 32'h0, 1'b0);
        checks++; if (xfer_cnt[3:0] !== 4'd0 || xfer_done !== 4'h1) begin errors++; $display("FAIL wrap: got cnt=%0d done=%h want 0/1", xfer_cnt[3:0], xfer_done); end
        checks++; if (xfer_cnt[15:4] !== 12'h0) begin errors++; $display("FAIL wrap_other_ch: got %h want 0", xfer_cnt[15:4]); end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; dValid = '0; dAck = '0; data = '0;
        test_reset();
        test_clean();
        test_lengths();
        test_hold_spur_noack();
        test_data();
        test_simultaneous();
        test_clear_overlap();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
